// File: rtl/mem_fill_wb.sv
// Cache-line fill engine with a 4-entry posted-write buffer.
// Buffered writes always drain before a read miss is accepted. A miss
// issues one full-line burst read and streams the returned words out
// as fill beats.
module mem_fill_wb #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int BURSTLEN_WIDTH = 3,
  parameter int LINE_WORDS     = 8
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          miss_req,
  input  logic [ADDR_WIDTH-1:0]         miss_addr,
  output logic                          miss_ack,
  output logic                          fill_valid,
  output logic [$clog2(LINE_WORDS)-1:0] fill_idx,
  output logic [DATA_WIDTH-1:0]         fill_data,
  output logic                          fill_done,
  input  logic                          wb_wr,
  input  logic [ADDR_WIDTH-1:0]         wb_addr,
  input  logic [DATA_WIDTH-1:0]         wb_data,
  output logic                          wb_full,
  output logic [ADDR_WIDTH-1:0]         m_addr,
  output logic [BURSTLEN_WIDTH-1:0]     m_burst_len,
  output logic [DATA_WIDTH-1:0]         m_data_out,
  output logic                          m_wr,
  output logic                          m_rd,
  input  logic [DATA_WIDTH-1:0]         m_data_in,
  input  logic                          m_waitrequest,
  input  logic                          m_rd_valid
);

  localparam int IDX_W = $clog2(LINE_WORDS);
  localparam int OFF_W = $clog2(LINE_WORDS * DATA_WIDTH / 8);

  typedef enum logic [1:0] {IDLE, WR_DRAIN, RD_REQ, RD_DATA} state_t;

  state_t                  state, next_state;
  logic [ADDR_WIDTH-1:0]   fifo_addr [4];
  logic [DATA_WIDTH-1:0]   fifo_data [4];
  logic [1:0]              wr_ptr, rd_ptr;
  logic [2:0]              count;
  logic [IDX_W-1:0]        word_cnt;
  logic [ADDR_WIDTH-1:0]   miss_addr_q;
  logic                    push, pop;

  // A write arriving while the buffer is full is lost, even if a pop
  // happens in the same cycle.
  assign wb_full = (count == 3'd4);
  assign push    = wb_wr && !wb_full;
  assign pop     = (state == WR_DRAIN) && !m_waitrequest;

  // Write-buffer storage; no reset needed since occupancy guards every read.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_addr[wr_ptr] <= wb_addr;
      fifo_data[wr_ptr] <= wb_data;
    end
  end

  // Write-buffer pointers and occupancy; pointers wrap naturally at 4.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      if (push && !pop)      count <= count + 3'd1;
      else if (pop && !push) count <= count - 3'd1;
    end
  end

  // Controller state, fill word counter and the accepted miss address.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= IDLE;
      word_cnt    <= '0;
      miss_addr_q <= '0;
    end else begin
      state <= next_state;
      if (miss_ack) miss_addr_q <= miss_addr;
      if (fill_valid) word_cnt <= fill_done ? '0 : word_cnt + 1'b1;
    end
  end

  // Next-state logic and all bus/fill outputs, which are quiet unless the
  // current state drives them.
  always_comb begin
    next_state  = state;
    miss_ack    = 1'b0;
    fill_valid  = 1'b0;
    fill_done   = 1'b0;
    fill_data   = '0;
    fill_idx    = word_cnt;
    m_addr      = '0;
    m_data_out  = '0;
    m_burst_len = '0;
    m_wr        = 1'b0;
    m_rd        = 1'b0;
    case (state)
      IDLE: begin
        if (count != 3'd0) begin
          next_state = WR_DRAIN;
        end else if (miss_req) begin
          miss_ack   = 1'b1;
          next_state = RD_REQ;
        end
      end
      WR_DRAIN: begin
        m_wr       = 1'b1;
        m_addr     = fifo_addr[rd_ptr];
        m_data_out = fifo_data[rd_ptr];
        if (pop && !push && count == 3'd1) next_state = IDLE;
      end
      RD_REQ: begin
        m_rd        = 1'b1;
        m_burst_len = BURSTLEN_WIDTH'(LINE_WORDS - 1);
        m_addr      = {miss_addr_q[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
        if (!m_waitrequest) next_state = RD_DATA;
      end
      RD_DATA: begin
        if (m_rd_valid) begin
          fill_valid = 1'b1;
          fill_data  = m_data_in;
          if (word_cnt == IDX_W'(LINE_WORDS - 1)) begin
            fill_done  = 1'b1;
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_fill_wb.sv
// Testbench for mem_fill_wb. Expected bus writes come from a queue of
// accepted pushes, expected line addresses from plain modulo arithmetic,
// and expected fill beats from the randomly generated return data.
module tb_mem_fill_wb;

  localparam int LINE_BYTES = 32;

  logic        clock;
  logic        reset_n;
  logic        miss_req;
  logic [31:0] miss_addr;
  logic        miss_ack;
  logic        fill_valid;
  logic [2:0]  fill_idx;
  logic [31:0] fill_data;
  logic        fill_done;
  logic        wb_wr;
  logic [31:0] wb_addr;
  logic [31:0] wb_data;
  logic        wb_full;
  logic [31:0] m_addr;
  logic [2:0]  m_burst_len;
  logic [31:0] m_data_out;
  logic        m_wr;
  logic        m_rd;
  logic [31:0] m_data_in;
  logic        m_waitrequest;
  logic        m_rd_valid;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  logic [63:0] exp_wr[$];
  logic [63:0] obs_wr[$];
  int cycle_n       = 0;
  int last_wr_cycle = 0;
  int ack_cycle     = 0;
  int both_cnt      = 0;

  mem_fill_wb dut (
    .clock(clock), .reset_n(reset_n),
    .miss_req(miss_req), .miss_addr(miss_addr), .miss_ack(miss_ack),
    .fill_valid(fill_valid), .fill_idx(fill_idx), .fill_data(fill_data),
    .fill_done(fill_done),
    .wb_wr(wb_wr), .wb_addr(wb_addr), .wb_data(wb_data), .wb_full(wb_full),
    .m_addr(m_addr), .m_burst_len(m_burst_len), .m_data_out(m_data_out),
    .m_wr(m_wr), .m_rd(m_rd), .m_data_in(m_data_in),
    .m_waitrequest(m_waitrequest), .m_rd_valid(m_rd_valid)
  );

  // Free-running clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Global time limit so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Bus monitor: logs accepted writes, miss acceptances and illegal overlap.
  always @(negedge clock) begin
    cycle_n <= cycle_n + 1;
    if (reset_n && m_wr && !m_waitrequest) begin
      obs_wr.push_back({m_addr, m_data_out});
      last_wr_cycle <= cycle_n;
    end
    if (miss_ack) ack_cycle <= cycle_n;
    if (m_wr && m_rd) both_cnt <= both_cnt + 1;
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total++;
    assert (observed === expected) begin
      passed++;
    end else begin
      failed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic [31:0] a,
                               input logic [31:0] d);
    wb_wr   = wr;
    wb_addr = a;
    wb_data = d;
  endtask

  task automatic checkWrites();
    int n = 0;
    while (obs_wr.size() < exp_wr.size() && n < 200) begin
      cyc();
      n++;
    end
    repeat (4) cyc();
    checkOutput("wr_count", obs_wr.size(), exp_wr.size());
    foreach (exp_wr[i]) begin
      if (i < obs_wr.size()) begin
        checkOutput("wr_addr", obs_wr[i][63:32], exp_wr[i][63:32]);
        checkOutput("wr_data", obs_wr[i][31:0], exp_wr[i][31:0]);
      end
    end
    exp_wr.delete();
    obs_wr.delete();
  endtask

  task automatic serviceMiss(input logic [31:0] addr, input int stall,
                             input bit push_mid);
    logic [31:0] line;
    logic [31:0] d;
    logic [31:0] wa;
    logic [31:0] wd;
    int n;
    int gap;
    line = addr - (addr % LINE_BYTES);
    cyc();
    applyStimulus(1'b0, 32'h0, 32'h0);
    m_rd_valid = 1'b0;
    miss_req = 1'b1;
    miss_addr = addr;
    m_waitrequest = 1'b0;
    #1;
    n = 0;
    while (!miss_ack && n < 100) begin
      cyc();
      #1;
      n++;
    end
    checkOutput("miss_ack", miss_ack, 1);
    cyc();
    miss_req = 1'b0;
    miss_addr = $urandom;
    m_waitrequest = (stall > 0);
    #1;
    checkOutput("miss_ack_pulse", miss_ack, 0);
    checkOutput("m_rd", m_rd, 1);
    checkOutput("m_rd_addr", m_addr, line);
    checkOutput("m_burst_len", m_burst_len, 7);
    checkOutput("m_wr_in_rd", m_wr, 0);
    for (int k = 1; k <= stall; k++) begin
      cyc();
      m_waitrequest = (k < stall);
      m_rd_valid = 1'b1;
      m_data_in = $urandom;
      miss_req = 1'b1;
      #1;
      checkOutput("m_rd_stall", m_rd, 1);
      checkOutput("m_addr_stall", m_addr, line);
      checkOutput("fill_valid_stall", fill_valid, 0);
      checkOutput("miss_ack_busy", miss_ack, 0);
    end
    cyc();
    miss_req = 1'b0;
    m_waitrequest = 1'b0;
    m_rd_valid = 1'b0;
    wa = $urandom;
    wd = $urandom;
    applyStimulus(push_mid, wa, wd);
    if (push_mid) exp_wr.push_back({wa, wd});
    #1;
    checkOutput("m_rd_data_phase", m_rd, 0);
    checkOutput("fill_valid_idle", fill_valid, 0);
    for (int i = 0; i < 8; i++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        cyc();
        applyStimulus(1'b0, 32'h0, 32'h0);
        m_rd_valid = 1'b0;
        #1;
        checkOutput("fill_valid_gap", fill_valid, 0);
      end
      cyc();
      applyStimulus(1'b0, 32'h0, 32'h0);
      d = $urandom;
      m_rd_valid = 1'b1;
      m_data_in = d;
      #1;
      checkOutput("fill_valid", fill_valid, 1);
      checkOutput("fill_idx", fill_idx, i);
      checkOutput("fill_data", fill_data, d);
      checkOutput("fill_done", fill_done, (i == 7));
      checkOutput("m_wr_in_burst", m_wr, 0);
    end
    cyc();
    m_rd_valid = 1'b1;
    m_data_in = $urandom;
    #1;
    checkOutput("stale_rd_valid", fill_valid, 0);
    checkOutput("m_rd_after_fill", m_rd, 0);
  endtask

  // Directed sequence of scenarios with randomized addresses and data.
  initial begin
    int occ;
    int n;
    logic [31:0] a;
    logic [31:0] d;
    reset_n = 1'b0;
    miss_req = 1'b0;
    miss_addr = 32'h0;
    m_data_in = 32'h0;
    m_waitrequest = 1'b0;
    m_rd_valid = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0);
    cyc();
    cyc();
    #1;
    checkOutput("rst_miss_ack", miss_ack, 0);
    checkOutput("rst_fill_valid", fill_valid, 0);
    checkOutput("rst_fill_done", fill_done, 0);
    checkOutput("rst_m_rd", m_rd, 0);
    checkOutput("rst_m_wr", m_wr, 0);
    checkOutput("rst_wb_full", wb_full, 0);
    checkOutput("rst_m_addr", m_addr, 0);
    checkOutput("rst_m_burst_len", m_burst_len, 0);
    cyc();
    reset_n = 1'b1;
    #1;

    $display("[TB] basic line fill at 0x1234");
    serviceMiss(32'h0000_1234, 0, 1'b0);

    $display("[TB] random misses with stalls and a write during the burst");
    for (int k = 0; k < 3; k++) serviceMiss($urandom, $urandom_range(0, 3), (k == 1));
    checkWrites();

    $display("[TB] long waitrequest stall on the read request");
    serviceMiss($urandom, 10, 1'b0);

    $display("[TB] buffered writes drain before a pending miss");
    cyc();
    m_waitrequest = 1'b1;
    a = $urandom; d = $urandom;
    applyStimulus(1'b1, a, d);
    exp_wr.push_back({a, d});
    #1;
    checkOutput("wb_full_one", wb_full, 0);
    cyc();
    a = $urandom; d = $urandom;
    applyStimulus(1'b1, a, d);
    exp_wr.push_back({a, d});
    #1;
    cyc();
    applyStimulus(1'b0, 32'h0, 32'h0);
    #1;
    checkOutput("drain_m_wr", m_wr, 1);
    checkOutput("drain_burst_len", m_burst_len, 0);
    checkOutput("drain_head_addr", m_addr, exp_wr[0][63:32]);
    serviceMiss($urandom, 0, 1'b0);
    checkOutput("ack_after_drain", (ack_cycle > last_wr_cycle), 1);
    checkWrites();

    $display("[TB] five pushes into a stalled buffer");
    occ = 0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      m_waitrequest = 1'b1;
      a = $urandom; d = $urandom;
      applyStimulus(1'b1, a, d);
      #1;
      checkOutput("wb_full_push", wb_full, (occ == 4));
      if (occ < 4) begin
        exp_wr.push_back({a, d});
        occ++;
      end
    end
    cyc();
    applyStimulus(1'b0, 32'h0, 32'h0);
    #1;
    checkOutput("wb_full_held", wb_full, 1);
    cyc();
    m_waitrequest = 1'b0;
    #1;
    checkWrites();
    checkOutput("wb_full_cleared", wb_full, 0);

    $display("[TB] simultaneous push and pop across pointer wrap");
    for (int k = 1; k <= 10; k++) begin
      cyc();
      m_waitrequest = (k <= 2);
      a = $urandom; d = $urandom;
      applyStimulus(1'b1, a, d);
      exp_wr.push_back({a, d});
      #1;
      if (k >= 3) begin
        checkOutput("wb_full_steady", wb_full, 0);
        checkOutput("pushpop_m_wr", m_wr, 1);
        checkOutput("pushpop_head", m_addr, exp_wr[k-3][63:32]);
      end
    end
    cyc();
    applyStimulus(1'b0, 32'h0, 32'h0);
    #1;
    checkOutput("drained_so_far", obs_wr.size(), 8);
    checkWrites();

    $display("[TB] reset in the middle of a burst");
    cyc();
    miss_req = 1'b1;
    miss_addr = $urandom;
    m_waitrequest = 1'b0;
    m_rd_valid = 1'b0;
    #1;
    n = 0;
    while (!miss_ack && n < 100) begin
      cyc();
      #1;
      n++;
    end
    checkOutput("rb_miss_ack", miss_ack, 1);
    cyc();
    miss_req = 1'b0;
    #1;
    checkOutput("rb_m_rd", m_rd, 1);
    cyc();
    #1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      m_rd_valid = 1'b1;
      m_data_in = $urandom;
      applyStimulus((i == 0), $urandom, $urandom);
      #1;
      checkOutput("rb_fill_idx", fill_idx, i);
    end
    cyc();
    m_rd_valid = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0);
    reset_n = 1'b0;
    #1;
    cyc();
    m_rd_valid = 1'b1;
    #1;
    checkOutput("mid_rst_fill_valid", fill_valid, 0);
    checkOutput("mid_rst_fill_done", fill_done, 0);
    checkOutput("mid_rst_m_rd", m_rd, 0);
    checkOutput("mid_rst_m_wr", m_wr, 0);
    checkOutput("mid_rst_miss_ack", miss_ack, 0);
    checkOutput("mid_rst_wb_full", wb_full, 0);
    checkOutput("mid_rst_m_addr", m_addr, 0);
    for (int k = 0; k < 5; k++) begin
      cyc();
      reset_n = 1'b1;
      m_rd_valid = 1'b1;
      m_data_in = $urandom;
      #1;
      checkOutput("post_rst_fill_valid", fill_valid, 0);
      checkOutput("post_rst_m_wr", m_wr, 0);
      checkOutput("post_rst_m_rd", m_rd, 0);
    end
    checkOutput("post_rst_no_writes", obs_wr.size(), 0);
    serviceMiss($urandom, 1, 1'b0);

    checkOutput("no_wr_rd_overlap", both_cnt, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
